// File: rtl/dmem_responder_pkg.sv
// Shared types for the dcache-port responder: FSM state encoding and the
// latched request record.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder.sv
// Data-memory responder: samples one request from the load/store queue,
// runs a single backing-memory transaction and returns a one-cycle d_resp
// pulse with byte-masked read data. Abandons the transaction after
// TIMEOUT_CYCLES cycles without mem_resp and flags a sticky error.
module dmem_responder
  import rv32i_types::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_rmask,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        busy,
  output logic        err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  dmem_state_t       state_q, state_d;
  dmem_req_t         req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              req_present;
  logic              timeout_hit;

  // Zero every byte lane whose mask bit is clear.
  function automatic logic [31:0] lane_mask(input logic [31:0] data,
                                            input logic [3:0]  mask);
    logic [31:0] res;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? data[8*i +: 8] : 8'h00;
    end
    return res;
  endfunction

  assign req_present = (|d_rmask) | (|d_wmask);
  // The cycle whose increment would bring the counter to TIMEOUT_CYCLES is
  // the last WAIT cycle, giving exactly TIMEOUT_CYCLES cycles of mem_read/write.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one transaction per request, RESP lasts one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_present) state_d = WAIT;
      WAIT:    if (mem_resp || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: request latch, timeout counter, response data, error.
  always_comb begin
    req_d   = req_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_present) begin
          req_d.addr  = d_addr;
          req_d.wdata = d_wdata;
          cnt_d       = '0;
          // A store mask wins over a read mask; the read side is dropped so
          // the response data comes back as zero.
          if (|d_wmask) begin
            req_d.wmask = d_wmask;
            req_d.rmask = '0;
            if (|d_rmask) err_d = 1'b1;
          end else begin
            req_d.wmask = '0;
            req_d.rmask = d_rmask;
          end
        end
      end
      WAIT: begin
        if (cnt_q != CNT_W'(TIMEOUT_CYCLES)) cnt_d = cnt_q + CNT_W'(1);
        if (mem_resp) begin
          rdata_d = lane_mask(mem_rdata, req_q.rmask);
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    d_rdata   = '0;
    d_resp    = 1'b0;
    mem_addr  = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wmask = '0;
    mem_wdata = '0;
    unique case (state_q)
      WAIT: begin
        mem_addr  = req_q.addr & 32'hFFFF_FFFC;
        mem_read  = |req_q.rmask;
        mem_write = |req_q.wmask;
        if (|req_q.wmask) begin
          mem_wmask = req_q.wmask;
          mem_wdata = req_q.wdata;
        end
      end
      RESP: begin
        d_resp  = 1'b1;
        d_rdata = rdata_q;
      end
      default: ;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of single transactions
// plus hand-written back-to-back, timeout and reset-mid-WAIT sequences.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] d_addr;
  logic [3:0]  d_rmask;
  logic [3:0]  d_wmask;
  logic [31:0] d_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  logic [31:0] d_rdata, mem_addr, mem_wdata;
  logic        d_resp, mem_read, mem_write, busy, err;
  logic [3:0]  mem_wmask;

  logic [31:0] t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_d_resp, t_mem_read, t_mem_write, t_busy, t_err;
  logic [3:0]  t_mem_wmask;

  int n_vec;
  int n_err;

  dmem_responder dut (
    .clk(clk), .rst(rst),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(busy), .err(err)
  );

  dmem_responder #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .rst(rst),
    .d_addr(d_addr), .d_rmask(d_rmask), .d_wmask(d_wmask), .d_wdata(d_wdata),
    .d_rdata(t_d_rdata), .d_resp(t_d_resp),
    .mem_addr(t_mem_addr), .mem_read(t_mem_read), .mem_write(t_mem_write),
    .mem_wmask(t_mem_wmask), .mem_wdata(t_mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .busy(t_busy), .err(t_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] mrdata;
    int unsigned delay;
    logic [31:0] e_maddr;
    logic        e_read;
    logic        e_write;
    logic [3:0]  e_wmask;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    d_addr  = '0;
    d_rmask = '0;
    d_wmask = '0;
    d_wdata = '0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    d_addr  = v.addr;
    d_rmask = v.rmask;
    d_wmask = v.wmask;
    d_wdata = v.wdata;
    @(negedge clk);
    clear_req();
    chk($sformatf("v%0d d_resp_in_wait", idx), {31'b0, d_resp}, 32'd0);
    chk($sformatf("v%0d mem_read", idx), {31'b0, mem_read}, {31'b0, v.e_read});
    chk($sformatf("v%0d mem_write", idx), {31'b0, mem_write}, {31'b0, v.e_write});
    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_maddr);
    chk($sformatf("v%0d mem_wmask", idx), {28'b0, mem_wmask}, {28'b0, v.e_wmask});
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
    repeat (v.delay) @(negedge clk);
    mem_resp  = 1'b1;
    mem_rdata = v.mrdata;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
    chk($sformatf("v%0d d_resp", idx), {31'b0, d_resp}, 32'd1);
    chk($sformatf("v%0d d_rdata", idx), d_rdata, v.e_rdata);
    chk($sformatf("v%0d err", idx), {31'b0, err}, {31'b0, v.e_err});
    @(negedge clk);
    chk($sformatf("v%0d d_resp_after", idx), {31'b0, d_resp}, 32'd0);
    chk($sformatf("v%0d busy_after", idx), {31'b0, busy}, 32'd0);
  endtask

  task automatic reset_both();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    clear_req();
    mem_rdata = '0;
    mem_resp  = 1'b0;

    //            addr          rm     wm     wdata         mrdata       dly maddr        rd wr wm     ewdata        erdata       err
    vecs[0] = '{32'h0000_1003, 4'h3, 4'h0, 32'h0,        32'hAABBCCDD, 2, 32'h0000_1000, 1, 0, 4'h0, 32'h0,        32'h0000_CCDD, 0};
    vecs[1] = '{32'h0000_2000, 4'h0, 4'hC, 32'h12345678, 32'hFFFF_FFFF, 0, 32'h0000_2000, 0, 1, 4'hC, 32'h12345678, 32'h0,        0};
    vecs[2] = '{32'h0000_3006, 4'hA, 4'h0, 32'h0,        32'h11223344, 1, 32'h0000_3004, 1, 0, 4'h0, 32'h0,        32'h1100_3300, 0};
    vecs[3] = '{32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0,        32'hDEADBEEF, 3, 32'hFFFF_FFFC, 1, 0, 4'h0, 32'h0,        32'hDEADBEEF, 0};
    vecs[4] = '{32'h0000_0040, 4'h0, 4'h1, 32'hA5A5A5A5, 32'hFFFF_FFFF, 0, 32'h0000_0040, 0, 1, 4'h1, 32'hA5A5A5A5, 32'h0,        0};
    vecs[5] = '{32'h0000_5001, 4'hF, 4'h1, 32'hCAFEBABE, 32'h99999999, 1, 32'h0000_5000, 0, 1, 4'h1, 32'hCAFEBABE, 32'h0,        1};
    vecs[6] = '{32'h0000_0010, 4'h1, 4'h0, 32'h0,        32'h123456AB, 0, 32'h0000_0010, 1, 0, 4'h0, 32'h0,        32'h0000_00AB, 1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst d_rdata", d_rdata, 32'd0);
    chk("rst d_resp", {31'b0, d_resp}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst mem_wmask", {28'b0, mem_wmask}, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst t_err", {31'b0, t_err}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) apply(vecs[i], i);

    // Back-to-back: request held through RESP, new head after dequeue.
    reset_both();
    @(negedge clk);
    d_addr  = 32'h0000_0100;
    d_rmask = 4'hF;
    @(negedge clk);
    chk("b2b w1 mem_read", {31'b0, mem_read}, 32'd1);
    mem_resp  = 1'b1;
    mem_rdata = 32'h11223344;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
    chk("b2b r1 d_resp", {31'b0, d_resp}, 32'd1);
    chk("b2b r1 d_rdata", d_rdata, 32'h11223344);
    @(negedge clk);
    chk("b2b idle d_resp", {31'b0, d_resp}, 32'd0);
    chk("b2b idle mem_read", {31'b0, mem_read}, 32'd0);
    chk("b2b idle busy", {31'b0, busy}, 32'd0);
    d_addr = 32'h0000_0104;
    @(negedge clk);
    chk("b2b w2 mem_read", {31'b0, mem_read}, 32'd1);
    chk("b2b w2 mem_addr", mem_addr, 32'h0000_0104);
    mem_resp  = 1'b1;
    mem_rdata = 32'h55667788;
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
    clear_req();
    chk("b2b r2 d_resp", {31'b0, d_resp}, 32'd1);
    chk("b2b r2 d_rdata", d_rdata, 32'h55667788);
    @(negedge clk);
    chk("b2b end d_resp", {31'b0, d_resp}, 32'd0);
    chk("b2b end busy", {31'b0, busy}, 32'd0);

    // Timeout on the TIMEOUT_CYCLES=4 instance, then a late mem_resp.
    reset_both();
    @(negedge clk);
    d_addr  = 32'h0000_0200;
    d_rmask = 4'hF;
    @(negedge clk);
    clear_req();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("to wait%0d mem_read", c), {31'b0, t_mem_read}, 32'd1);
      chk($sformatf("to wait%0d d_resp", c), {31'b0, t_d_resp}, 32'd0);
      @(negedge clk);
    end
    chk("to d_resp", {31'b0, t_d_resp}, 32'd1);
    chk("to d_rdata", t_d_rdata, 32'd0);
    chk("to err", {31'b0, t_err}, 32'd1);
    chk("to mem_read_off", {31'b0, t_mem_read}, 32'd0);
    mem_resp  = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("to late1 d_resp", {31'b0, t_d_resp}, 32'd0);
    chk("to late1 busy", {31'b0, t_busy}, 32'd0);
    @(negedge clk);
    mem_resp  = 1'b0;
    mem_rdata = '0;
    chk("to late2 d_resp", {31'b0, t_d_resp}, 32'd0);
    chk("to late2 busy", {31'b0, t_busy}, 32'd0);
    chk("to err sticky", {31'b0, t_err}, 32'd1);

    // Reset asserted mid-WAIT (both-mask store, so err is set beforehand).
    reset_both();
    @(negedge clk);
    d_addr  = 32'h0000_0300;
    d_rmask = 4'hF;
    d_wmask = 4'h3;
    d_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    clear_req();
    chk("rw pre mem_write", {31'b0, mem_write}, 32'd1);
    chk("rw pre err", {31'b0, err}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("rw async mem_write", {31'b0, mem_write}, 32'd0);
    chk("rw async busy", {31'b0, busy}, 32'd0);
    chk("rw async err", {31'b0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("rw post%0d d_resp", c), {31'b0, d_resp}, 32'd0);
      chk($sformatf("rw post%0d busy", c), {31'b0, busy}, 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
